// File: rtl/qarma64_sched.sv
// qarma64_sched -- request scheduler in front of a QARMA-64 cipher core.
//
// Requests {tweak,data} are queued in a FIFO_DEPTH-entry FIFO. A small
// IDLE/LOAD/RUN FSM pops the FIFO head into registered core operands, pulses
// core_reset_n low for one cycle to start the core, waits for core_ready and
// captures core_out into a single-entry result slot (rsp_valid/rsp_data).
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_data, req_tweak         64-bit plaintext and tweak
//   key                         128-bit {w0,k0}, sampled on entry to LOAD
//   rsp_valid/rsp_ready         result handshake, rsp_data = ciphertext
//   core_reset_n                core start strobe (low = load)
//   core_in/core_tweak/core_key registered operands to the core
//   core_out, core_ready        core result and idle flag
//   busy                        FSM not IDLE or FIFO non-empty
//
// Option: define QARMA64_SCHED_TWEAK_CTR_EN to replace req_tweak by an
// internal 64-bit counter that advances once per accepted request.

module qarma64_sched #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [63:0]  req_data,
    input  logic [63:0]  req_tweak,
    input  logic [127:0] key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [63:0]  rsp_data,
    output logic         core_reset_n,
    output logic [63:0]  core_in,
    output logic [63:0]  core_tweak,
    output logic [127:0] core_key,
    input  logic [63:0]  core_out,
    input  logic         core_ready,
    output logic         busy
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          first_q;          // first RUN cycle: core_ready still stale
    logic [127:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [63:0]   rsp_data_q;
    logic [63:0]   core_in_q, core_tweak_q;
    logic [127:0]  core_key_q;

    logic          empty, full, push, capture, load_go;
    logic [127:0]  head;
    logic [63:0]   fifo_tweak;

`ifdef QARMA64_SCHED_TWEAK_CTR_EN
    logic [63:0] tw_ctr_q;
    logic        unused_req_tweak;

    assign unused_req_tweak = ^req_tweak;
    assign fifo_tweak       = tw_ctr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tw_ctr_q <= '0;
        end else if (push) begin
            tw_ctr_q <= tw_ctr_q + 64'd1;
        end
    end
`else
    assign fifo_tweak = req_tweak;
`endif

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign req_ready = !full && !reset;
    assign push      = req_valid && req_ready;
    assign head      = mem_q[rd_ptr_q];

    // Capture only after the first RUN cycle, and only into a free slot.
    assign capture = (state_q == S_RUN) && !first_q && core_ready &&
                     (!rsp_valid_q || rsp_ready);

    // Pop the head and latch operands on every entry into LOAD.
    assign load_go = !empty && ((state_q == S_IDLE) || capture);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   if (capture) state_d = empty ? S_IDLE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, load_go})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        if (capture) begin
            rsp_valid_d = 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {fifo_tweak, req_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            first_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            core_in_q    <= '0;
            core_tweak_q <= '0;
            core_key_q   <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= (state_q == S_LOAD);
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (load_go) begin
                rd_ptr_q     <= rd_ptr_q + 1'b1;
                core_in_q    <= head[63:0];
                core_tweak_q <= head[127:64];
                core_key_q   <= key;
            end
            if (capture) begin
                rsp_data_q <= core_out;
            end
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign core_in      = core_in_q;
    assign core_tweak   = core_tweak_q;
    assign core_key     = core_key_q;
    assign core_reset_n = (state_q != S_LOAD);
    assign busy         = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_qarma64_sched.sv
// tb_qarma64_sched -- self-checking bench for qarma64_sched.
// Contains a behavioural cipher-core model (16-cycle busy period, stale
// core_ready in the cycle after the start strobe) and an in-order scoreboard
// of expected ciphertexts computed at request acceptance.

module tb_qarma64_sched;

    localparam logic [127:0] KAT_KEY = 128'h84be85ce9804e94b_ec2802d4e0a488e9;
    localparam logic [63:0]  KAT_PT  = 64'hfb623599da6e8127;
    localparam logic [63:0]  KAT_TW  = 64'h477d469dec0b8762;
    localparam logic [63:0]  KAT_CT  = 64'h3ee99a6c82af0c38;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [63:0]  req_data;
    logic [63:0]  req_tweak;
    logic [127:0] key;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [63:0]  rsp_data;
    logic         core_reset_n;
    logic [63:0]  core_in;
    logic [63:0]  core_tweak;
    logic [127:0] core_key;
    logic [63:0]  core_out = '0;
    logic         core_ready = 1'b1;
    logic         busy;

    int unsigned  tests = 0;
    int unsigned  fails = 0;
    int unsigned  cyc = 0;
    int unsigned  last_acc = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  tw_ctr = '0;

    qarma64_sched #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_tweak    (req_tweak),
        .key          (key),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .core_reset_n (core_reset_n),
        .core_in      (core_in),
        .core_tweak   (core_tweak),
        .core_key     (core_key),
        .core_out     (core_out),
        .core_ready   (core_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in cipher: the known-answer vector, otherwise a keyed mix.
    function automatic logic [63:0] cipher(input logic [63:0] d, input logic [63:0] t,
                                           input logic [127:0] k);
        logic [63:0] x;
        if (d == KAT_PT && t == KAT_TW && k == KAT_KEY) return KAT_CT;
        x = (d ^ k[63:0]) * 64'h9e3779b97f4a7c15;
        x = x ^ {t[31:0], t[63:32]} ^ k[127:64];
        x = (x * 64'hbf58476d1ce4e5b9) ^ (x >> 29);
        return x;
    endfunction

    // Core model: start on core_reset_n low, ready again 16 edges later.
    logic [63:0]  c_in, c_tw;
    logic [127:0] c_key;
    int unsigned  ccnt = 0;
    always @(posedge clk) begin
        if (!core_reset_n) begin
            c_in  <= core_in;
            c_tw  <= core_tweak;
            c_key <= core_key;
            ccnt  <= 16;
        end else if (ccnt != 0) begin
            ccnt       <= ccnt - 1;
            core_ready <= (ccnt == 1);
            if (ccnt == 1) core_out <= cipher(c_in, c_tw, c_key);
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Compare process: in-order results, no spurious results, hold stability.
    logic        prev_hold = 1'b0;
    logic [63:0] prev_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", rsp_valid, 1'b1);
                check("hold_data", rsp_data, prev_data);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 1'b0);
                else if (rsp_ready) check("rsp_data", rsp_data, exp_q.pop_front());
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [63:0] d, input logic [63:0] t);
        int unsigned n = 0;
        req_valid = 1'b1;
        req_data  = d;
        req_tweak = t;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("push_timeout", req_ready, 1'b1);
        end else begin
`ifdef QARMA64_SCHED_TWEAK_CTR_EN
            exp_q.push_back(cipher(d, tw_ctr, key));
            tw_ctr = tw_ctr + 64'd1;
`else
            exp_q.push_back(cipher(d, t, key));
`endif
            last_acc = cyc + 1;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic reset_checks();
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_core_in", core_in, 64'h0);
        check("rst_core_tweak", core_tweak, 64'h0);
        check("rst_core_key", core_key, 128'h0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_core_reset_n", core_reset_n, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        #1 reset_checks();
        exp_q.delete();
        tw_ctr = '0;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        logic        done;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        req_tweak = '0;
        key       = KAT_KEY;
        rsp_ready = 1'b1;
        #2 reset_checks();
        idle(3);
        reset = 1'b0;
        idle(2);

        // Known-answer request and its latency from the accepting edge.
        push(KAT_PT, KAT_TW);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        check("latency_valid", rsp_valid, 1'b1);
        check("latency_edges", cyc - last_acc, 19);
`ifndef QARMA64_SCHED_TWEAK_CTR_EN
        check("kat_ct", rsp_data, KAT_CT);
`endif
        idle(3);

        // Key changes while an operation is in flight must not leak in.
        push({$urandom, $urandom}, {$urandom, $urandom});
        idle(6);
        key = {$urandom, $urandom, $urandom, $urandom};
        idle(30);
        key = KAT_KEY;
        check("key_isolation_drained", exp_q.size(), 0);

        // Back-to-back burst: accepts before full, result spacing.
        fork
            begin
                for (int i = 0; i < 6; i++) push({$urandom, $urandom}, {$urandom, $urandom});
            end
            begin
                int unsigned na = 0;
                int unsigned w = 0;
                @(negedge clk);
                while (!(req_valid && !req_ready) && w < 200) begin
                    if (req_valid && req_ready) na++;
                    w++;
                    @(negedge clk);
                end
                check("accepts_before_full", na, 5);
            end
            begin
                int unsigned t_prev = 0;
                for (int i = 0; i < 6; i++) begin
                    int unsigned w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!rsp_valid && w < 200);
                    check("burst_rsp_seen", rsp_valid, 1'b1);
                    if (i > 0) check("burst_spacing", cyc - t_prev, 18);
                    t_prev = cyc;
                end
            end
        join
        idle(5);
        check("burst_drained", exp_q.size(), 0);

        // Back-pressure: one result held, one parked in the core, one queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push({$urandom, $urandom}, {$urandom, $urandom});
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i >= 60 && !core_reset_n) n++;
        end
        check("park_no_load", n, 0);
        check("park_rsp_valid", rsp_valid, 1'b1);
        check("park_busy", busy, 1'b1);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        idle(60);
        check("park_drained", exp_q.size(), 0);

        // Reset five cycles into RUN with three requests queued.
        for (int i = 0; i < 4; i++) push({$urandom, $urandom}, {$urandom, $urandom});
        idle(3);
        do_reset();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("post_reset_no_rsp", n, 0);
        check("post_reset_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        key = KAT_KEY;
        push(KAT_PT, KAT_TW);
        idle(25);
        check("post_reset_drained", exp_q.size(), 0);
`ifndef QARMA64_SCHED_TWEAK_CTR_EN
        check("post_reset_kat", rsp_data, KAT_CT);
`endif

        // Randomised traffic with random result back-pressure.
        key  = {$urandom, $urandom, $urandom, $urandom};
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    idle($urandom_range(0, 20));
                    push({$urandom, $urandom}, {$urandom, $urandom});
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        idle(150);
        check("random_drained", exp_q.size(), 0);

`ifdef QARMA64_SCHED_TWEAK_CTR_EN
        // Counter tweaks 0,1,2 on identical data give distinct ciphertexts.
        do_reset();
        begin
            logic [63:0] r [3];
            fork
                begin
                    for (int i = 0; i < 3; i++) push(KAT_PT, {$urandom, $urandom});
                end
                begin
                    for (int i = 0; i < 3; i++) begin
                        int unsigned w = 0;
                        do begin
                            @(negedge clk);
                            w++;
                        end while (core_reset_n && w < 200);
                        check("ctr_load_seen", core_reset_n, 1'b0);
                        check("ctr_tweak", core_tweak, 64'(i));
                    end
                end
                begin
                    for (int i = 0; i < 3; i++) begin
                        int unsigned w = 0;
                        do begin
                            @(negedge clk);
                            w++;
                        end while (!(rsp_valid && rsp_ready) && w < 200);
                        check("ctr_rsp_seen", rsp_valid, 1'b1);
                        r[i] = rsp_data;
                    end
                end
            join
            check("ctr_distinct01", r[0] != r[1], 1'b1);
            check("ctr_distinct12", r[1] != r[2], 1'b1);
            check("ctr_distinct02", r[0] != r[2], 1'b1);
        end
        idle(5);
        check("ctr_drained", exp_q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
